// File: rtl/led_arbiter.sv
// Front-panel LED bank arbiter: round-robin sharing of the 8-bit LED bank between four
// status sources and the idle pattern. Define LED_FLASH_EN to add an all-on tick on every source change.
module led_arbiter #(
    parameter int unsigned MXPRE = 21,
    parameter int unsigned HOLD  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  idle_pat,
    input  logic [3:0]  req,
    input  logic [31:0] dat,
    output logic [3:0]  gnt,
    output logic        busy,
    output logic        tick,
    output logic [7:0]  q
);

    localparam int unsigned HOLD_EFF = (HOLD == 0) ? 1 : HOLD;
    localparam logic [3:0]  HOLD_LD  = 4'(HOLD_EFF);

`ifdef LED_FLASH_EN
    typedef enum logic [1:0] {IDLE, GRANT, FLASH} state_t;
`else
    typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

    state_t           state;
    logic [MXPRE-1:0] pre;
    logic [1:0]       ptr;
    logic [1:0]       sel;
    logic [3:0]       hcnt;
    logic [7:0]       latch;
    logic [1:0]       win;
    logic             any;
    logic [7:0]       sel_dat;
    logic             cur_req;

    // Visual-rate prescaler; tick marks the clock on which decisions are taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre  <= '0;
            tick <= 1'b0;
        end else begin
            pre  <= pre + 1'b1;
            tick <= (pre == '1);
        end
    end

    // Round-robin search starting just after the last granted index.
    always_comb begin
        logic found;
        found = 1'b0;
        win   = ptr;
        for (int unsigned i = 1; i <= 4; i++) begin
            if (!found && req[ptr + 2'(i)]) begin
                win   = ptr + 2'(i);
                found = 1'b1;
            end
        end
    end

    assign any     = |req;
    assign sel_dat = dat[{sel, 3'b000} +: 8];
    assign cur_req = req[sel];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sel   <= 2'd0;
            ptr   <= 2'd3;
            hcnt  <= 4'd0;
            latch <= 8'h00;
            q     <= 8'h00;
            gnt   <= 4'b0000;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    q <= idle_pat;
                    if (tick && any) begin
                        sel   <= win;
                        ptr   <= win;
                        hcnt  <= HOLD_LD;
                        gnt   <= 4'b0001 << win;
                        busy  <= 1'b1;
`ifdef LED_FLASH_EN
                        state <= FLASH;
`else
                        state <= GRANT;
`endif
                    end
                end
                GRANT: begin
                    // The latch freezes once the granted source drops its request.
                    if (cur_req) begin
                        latch <= sel_dat;
                        q     <= sel_dat;
                    end else begin
                        q     <= latch;
                    end
                    if (tick) begin
                        if (hcnt > 4'd1) begin
                            hcnt <= hcnt - 4'd1;
                        end else if (!any) begin
                            hcnt  <= 4'd0;
                            gnt   <= 4'b0000;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            sel  <= win;
                            ptr  <= win;
                            hcnt <= HOLD_LD;
                            gnt  <= 4'b0001 << win;
`ifdef LED_FLASH_EN
                            if (win != sel) state <= FLASH;
`endif
                        end
                    end
                end
`ifdef LED_FLASH_EN
                FLASH: begin
                    q <= 8'hFF;
                    if (cur_req) latch <= sel_dat;
                    if (tick) state <= GRANT;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter with MXPRE=4, HOLD=2; flash checks follow LED_FLASH_EN.
module tb_led_arbiter;

`ifdef LED_FLASH_EN
    localparam int FL = 16;
`else
    localparam int FL = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  idle_pat = 8'h00;
    logic [3:0]  req = 4'b0000;
    logic [31:0] dat = 32'h0;
    logic [3:0]  gnt;
    logic        busy;
    logic        tick;
    logic [7:0]  q;

    int errors = 0;
    int checks = 0;

    led_arbiter #(.MXPRE(4), .HOLD(2)) dut (
        .clock(clock), .reset(reset), .idle_pat(idle_pat), .req(req), .dat(dat),
        .gnt(gnt), .busy(busy), .tick(tick), .q(q)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Leaves the bench 1 time unit after edge 0; edge N is then N clocks after release.
    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic async_reset_check(input string tag);
        reset = 1'b1;
        #2;
        check({tag, "_q"},    32'(q),    32'h0);
        check({tag, "_gnt"},  32'(gnt),  32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_tick"}, 32'(tick), 32'h0);
    endtask

    initial begin
        // Reset state and idle tracking.
        step(1);
        check("rst_q", 32'(q), 32'h0);
        check("rst_gnt", 32'(gnt), 32'h0);
        do_reset();
        idle_pat = 8'h01;
        step(1);
        check("idle_q0", 32'(q), 32'h01);
        check("tick_e1", 32'(tick), 32'h0);
        idle_pat = 8'h5A;
        step(1);
        check("idle_q1", 32'(q), 32'h5A);
        step(13);
        check("tick_e15", 32'(tick), 32'h0);
        step(1);
        check("tick_e16", 32'(tick), 32'h1);
        check("idle_gnt", 32'(gnt), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        step(1);
        check("tick_e17", 32'(tick), 32'h0);
        check("idle_gnt17", 32'(gnt), 32'h0);

`ifndef LED_FLASH_EN
        // All four requesting: rotation 0,1,2,3,0,1 with 32-clock grants.
        req = 4'b1111;
        dat = 32'hA3A2A1A0;
        step(16);
        for (int k = 0; k < 5; k++) begin
            check("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
            check("rr_busy", 32'(busy), 32'h1);
            step(1);
            check("rr_q", 32'(q), 32'(8'hA0 + 8'(k % 4)));
            step(30);
            check("rr_hold", 32'(gnt), 32'(4'b0001 << (k % 4)));
            step(1);
        end
        check("rr_gnt5", 32'(gnt), 32'h2);
`else
        // Flash: req[1] alone, then req[3] joins.
        do_reset();
        req = 4'b0010;
        dat = 32'hB3B2B1B0;
        step(17);
        check("fl_gnt1", 32'(gnt), 32'h2);
        step(1);
        check("fl_ff1a", 32'(q), 32'hFF);
        step(15);
        check("fl_ff1b", 32'(q), 32'hFF);
        step(1);
        check("fl_dat1", 32'(q), 32'hB1);
        step(6);
        req = 4'b1010;
        step(24);
        check("fl_hold1", 32'(gnt), 32'h2);
        check("fl_hold1q", 32'(q), 32'hB1);
        step(1);
        check("fl_gnt3", 32'(gnt), 32'h8);
        step(1);
        check("fl_ff3a", 32'(q), 32'hFF);
        step(15);
        check("fl_ff3b", 32'(q), 32'hFF);
        step(1);
        check("fl_dat3", 32'(q), 32'hB3);
`endif

        // Asynchronous reset mid-grant (mid-FLASH with flash on), then source 0 wins first.
        do_reset();
        req = 4'b1111;
        dat = 32'hA3A2A1A0;
        idle_pat = 8'h81;
        step(17);
        check("pre_gnt", 32'(gnt), 32'h1);
        step(3);
        async_reset_check("rst_mid");
        do_reset();
        step(16);
        check("post_q", 32'(q), 32'h81);
        check("post_gnt16", 32'(gnt), 32'h0);
        step(1);
        check("post_gnt17", 32'(gnt), 32'h1);
        step(1);
        check("post_q18", 32'(q), (FL != 0) ? 32'hFF : 32'hA0);

        // req[2] with stepping data, dropped mid-hold: q freezes, grant held to expiry.
        do_reset();
        idle_pat = 8'h3C;
        req = 4'b0100;
        dat = 32'h0;
        step(17);
        check("frz_gnt", 32'(gnt), 32'h4);
        check("frz_busy", 32'(busy), 32'h1);
`ifdef LED_FLASH_EN
        step(16);
        check("frz_ff", 32'(q), 32'hFF);
`endif
        for (int i = 0; i < 10; i++) begin
            dat[23:16] = 8'h40 + 8'(i);
            step(1);
            check("frz_track", 32'(q), 32'(8'h40 + 8'(i)));
        end
        req = 4'b0000;
        for (int j = 0; j < 5; j++) begin
            dat[23:16] = 8'h70 + 8'(j);
            step(1);
            check("frz_hold", 32'(q), 32'h49);
        end
        step(16);
        check("frz_gnt_end", 32'(gnt), 32'h4);
        step(1);
        check("frz_gnt_off", 32'(gnt), 32'h0);
        check("frz_busy_off", 32'(busy), 32'h0);
        step(1);
        check("frz_idle", 32'(q), 32'h3C);

        // req[0] alone through five expiries: continuous grant, no flash after the first.
        do_reset();
        req = 4'b0001;
        dat = 32'h000000C0;
        step(18 + FL);
        for (int i = 0; i < 180; i++) begin
            check("regrant_gnt", 32'(gnt), 32'h1);
            check("regrant_q", 32'(q), 32'hC0);
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
